// File: rtl/instruction_decode_stage_if.sv
// Bus interface of the instruction decode stage: upstream instruction
// handshake, downstream head-entry handshake and the decoded fields.
// The "slave" modport is the decode stage itself; "master" is whatever
// surrounds it (fetch on the input side, register-read on the output side).
interface instruction_decode_stage_if #(
    parameter int INSTR_W  = 32,
    parameter int OPCODE_W = 6,
    parameter int REG_W    = 5,
    parameter int FUNC_W   = 5,
    parameter int IMM_W    = 16,
    parameter int DATA_W   = 32,
    parameter int CNT_W    = 16
);
    logic                         in_valid;
    logic                         in_ready;
    logic [INSTR_W-1:0]           in_instr;
    logic                         out_valid;
    logic                         out_ready;
    logic [OPCODE_W-1:0]          opcode;
    logic [REG_W-1:0]             rs;
    logic [REG_W-1:0]             rt;
    logic [REG_W-1:0]             shamt;
    logic [FUNC_W-1:0]            func;
    logic [IMM_W-1:0]             imm;
    logic [DATA_W-1:0]            imm_ext;
    logic [INSTR_W-OPCODE_W-1:0]  jaddr;
    logic                         is_rtype;
    logic [CNT_W-1:0]             dec_count;

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, opcode, rs, rt, shamt, func,
               imm, imm_ext, jaddr, is_rtype, dec_count
    );

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, opcode, rs, rt, shamt, func,
               imm, imm_ext, jaddr, is_rtype, dec_count
    );
endinterface

// File: rtl/instruction_decode_stage.sv
// Instruction decode stage: a 2-entry skid FIFO of raw instructions whose
// head entry is sliced into its fields. in_ready depends on registered
// occupancy only, so there is no combinational path from out_ready back to
// the fetch side. Field outputs are forced to zero while no entry is held.
module instruction_decode_stage #(
    parameter int INSTR_W  = 32,
    parameter int OPCODE_W = 6,
    parameter int REG_W    = 5,
    parameter int FUNC_W   = 5,
    parameter int IMM_W    = 16,
    parameter int DATA_W   = 32,
    parameter bit SEXT_IMM = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    instruction_decode_stage_if.slave bus
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]         state_r;
    logic [1:0]         state_next_s;
    logic [INSTR_W-1:0] head_r;
    logic [INSTR_W-1:0] head_next_s;
    logic [INSTR_W-1:0] tail_r;
    logic [INSTR_W-1:0] tail_next_s;
    logic [CNT_W-1:0]   count_r;
    logic               valid_s;
    logic               push_s;
    logic               pop_s;

    // Widen the raw immediate to the datapath width (sign or zero fill).
    function automatic logic [DATA_W-1:0] extend_imm(input logic [IMM_W-1:0] raw);
        logic [DATA_W-1:0] res;
        if (SEXT_IMM) begin
            res = DATA_W'($signed(raw));
        end else begin
            res = DATA_W'(raw);
        end
        return res;
    endfunction

    assign valid_s       = (state_r != EMPTY);
    assign bus.in_ready  = (state_r != FULL);
    assign bus.out_valid = valid_s;
    assign push_s        = bus.in_valid & bus.in_ready;
    assign pop_s         = valid_s & bus.out_ready;
    assign bus.dec_count = count_r;

    // Next occupancy and storage contents; flush wins over push and pop.
    always_comb begin
        state_next_s = state_r;
        head_next_s  = head_r;
        tail_next_s  = tail_r;
        if (flush) begin
            state_next_s = EMPTY;
            head_next_s  = '0;
            tail_next_s  = '0;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (push_s) begin
                        head_next_s  = bus.in_instr;
                        state_next_s = ONE;
                    end else begin
                        state_next_s = EMPTY;
                    end
                end
                ONE: begin
                    if (push_s && pop_s) begin
                        // old head leaves, the new word becomes head
                        head_next_s  = bus.in_instr;
                        state_next_s = ONE;
                    end else if (push_s) begin
                        tail_next_s  = bus.in_instr;
                        state_next_s = FULL;
                    end else if (pop_s) begin
                        head_next_s  = '0;
                        state_next_s = EMPTY;
                    end else begin
                        state_next_s = ONE;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can happen
                    if (pop_s) begin
                        head_next_s  = tail_r;
                        tail_next_s  = '0;
                        state_next_s = ONE;
                    end else begin
                        state_next_s = FULL;
                    end
                end
                default: begin
                    state_next_s = EMPTY;
                    head_next_s  = '0;
                    tail_next_s  = '0;
                end
            endcase
        end
    end

    // Occupancy and storage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= EMPTY;
            head_r  <= '0;
            tail_r  <= '0;
        end else begin
            state_r <= state_next_s;
            head_r  <= head_next_s;
            tail_r  <= tail_next_s;
        end
    end

    // Completed output handshakes; counts even when a flush coincides, wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (pop_s) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    // Field slicing of the head entry, zero when nothing is held.
    always_comb begin
        bus.opcode   = valid_s ? head_r[INSTR_W-1 -: OPCODE_W] : '0;
        bus.rs       = valid_s ? head_r[INSTR_W-OPCODE_W-1 -: REG_W] : '0;
        bus.rt       = valid_s ? head_r[INSTR_W-OPCODE_W-REG_W-1 -: REG_W] : '0;
        bus.shamt    = valid_s ? head_r[IMM_W-1 -: REG_W] : '0;
        bus.func     = valid_s ? head_r[FUNC_W-1:0] : '0;
        bus.imm      = valid_s ? head_r[IMM_W-1:0] : '0;
        bus.imm_ext  = valid_s ? extend_imm(head_r[IMM_W-1:0]) : '0;
        bus.jaddr    = valid_s ? head_r[INSTR_W-OPCODE_W-1:0] : '0;
        bus.is_rtype = valid_s && (head_r[INSTR_W-1 -: OPCODE_W] == '0);
    end

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Bench for instruction_decode_stage. Two instances share every input: one
// with sign extension and a 16-bit counter, one with zero extension and a
// 4-bit counter. A queue-based reference model tracks the buffered words and
// the number of completed output handshakes.
module tb_instruction_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        out_ready;

    always #5 clk = ~clk;

    instruction_decode_stage_if #(.CNT_W(16)) bus0 ();
    instruction_decode_stage_if #(.CNT_W(4))  bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_instr  = in_instr;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_instr  = in_instr;
    assign bus1.out_ready = out_ready;

    instruction_decode_stage #(.SEXT_IMM(1'b1), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus0));
    instruction_decode_stage #(.SEXT_IMM(1'b0), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus1));

    int total  = 0;
    int passed = 0;

    logic [31:0] model_q[$];
    logic [31:0] popped[$];
    int          exp_count = 0;

    typedef struct {
        logic [31:0] instr;
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  shamt;
        logic [4:0]  func;
        logic [15:0] imm;
        logic [31:0] ext_s;
        logic [31:0] ext_z;
        logic [25:0] jaddr;
        logic        rtype;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare both instances against the reference model's current contents.
    task automatic check_state();
        logic [31:0] w;
        logic        v;
        int unsigned im;
        v  = (model_q.size() > 0);
        w  = v ? model_q[0] : 32'h0;
        im = w % 65536;
        chk("out_valid", bus0.out_valid, v);
        chk("in_ready", bus0.in_ready, model_q.size() < 2);
        chk("dec_count", bus0.dec_count, exp_count % 65536);
        chk("dec_count_w4", bus1.dec_count, exp_count % 16);
        chk("head_word", {bus0.opcode, bus0.jaddr}, w);
        chk("head_word_w4", {bus1.opcode, bus1.jaddr}, w);
        chk("rs", bus0.rs, (w >> 21) % 32);
        chk("rt", bus0.rt, (w >> 16) % 32);
        chk("shamt", bus0.shamt, (w >> 11) % 32);
        chk("func", bus0.func, w % 32);
        chk("imm", bus0.imm, im);
        chk("imm_ext_sext", bus0.imm_ext, (im >= 32768) ? (im + 32'hFFFF_0000) : im);
        chk("imm_ext_zext", bus1.imm_ext, im);
        chk("is_rtype", bus0.is_rtype, v && ((w >> 26) == 0));
    endtask

    // One clock: work out push/pop from the model, advance it, then compare.
    task automatic tick(output bit pushed);
        bit push, pop;
        push = in_valid && (model_q.size() < 2);
        pop  = out_ready && (model_q.size() > 0);
        @(posedge clk);
        #1;
        if (pop) begin
            popped.push_back(model_q[0]);
            void'(model_q.pop_front());
            exp_count++;
        end
        if (flush) begin
            model_q.delete();
        end else if (push) begin
            model_q.push_back(in_instr);
        end
        pushed = push && !flush;
        check_state();
    endtask

    task automatic step();
        bit dummy;
        tick(dummy);
    endtask

    // Asynchronous reset raised between clock edges; outputs must clear at once.
    task automatic async_reset(input bit check_now);
        #3;
        rst = 1'b1;
        #1;
        if (check_now) begin
            chk("rst_out_valid", bus0.out_valid, 1'b0);
            chk("rst_in_ready", bus0.in_ready, 1'b1);
            chk("rst_dec_count", bus0.dec_count, 16'd0);
            chk("rst_dec_count_w4", bus1.dec_count, 4'd0);
            chk("rst_fields", {bus0.opcode, bus0.jaddr, bus0.imm_ext, bus0.is_rtype}, 64'd0);
        end
        model_q.delete();
        exp_count = 0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_state();
    endtask

    initial begin
        bit  got;
        int  base;
        bit  c_in;

        vecs[0] = '{32'h0443_8005, 6'd1, 5'd2, 5'd3, 5'd16, 5'd5, 16'h8005,
                    32'hFFFF_8005, 32'h0000_8005, 26'h043_8005, 1'b0};
        vecs[1] = '{32'h0000_0000, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0000,
                    32'h0000_0000, 32'h0000_0000, 26'h000_0000, 1'b1};
        vecs[2] = '{32'hFFFF_FFFF, 6'd63, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF,
                    32'hFFFF_FFFF, 32'h0000_FFFF, 26'h3FF_FFFF, 1'b0};
        vecs[3] = '{32'h03E0_7FE8, 6'd0, 5'd31, 5'd0, 5'd15, 5'd8, 16'h7FE8,
                    32'h0000_7FE8, 32'h0000_7FE8, 26'h3E0_7FE8, 1'b1};
        vecs[4] = '{32'h8C22_0004, 6'd35, 5'd1, 5'd2, 5'd0, 5'd4, 16'h0004,
                    32'h0000_0004, 32'h0000_0004, 26'h022_0004, 1'b0};

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_state();

        // Table-driven decode: push, check fields one cycle later, pop.
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            in_instr  = vecs[i].instr;
            out_ready = 1'b0;
            step();
            in_valid = 1'b0;
            chk("tbl_valid", bus0.out_valid, 1'b1);
            chk("tbl_opcode", bus0.opcode, vecs[i].opcode);
            chk("tbl_rs", bus0.rs, vecs[i].rs);
            chk("tbl_rt", bus0.rt, vecs[i].rt);
            chk("tbl_shamt", bus0.shamt, vecs[i].shamt);
            chk("tbl_func", bus0.func, vecs[i].func);
            chk("tbl_imm", bus0.imm, vecs[i].imm);
            chk("tbl_imm_ext_s", bus0.imm_ext, vecs[i].ext_s);
            chk("tbl_imm_ext_z", bus1.imm_ext, vecs[i].ext_z);
            chk("tbl_jaddr", bus0.jaddr, vecs[i].jaddr);
            chk("tbl_is_rtype", bus0.is_rtype, vecs[i].rtype);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end

        // Reset mid-stream with both entries occupied.
        in_valid = 1'b1;
        in_instr = 32'h1234_5678;
        step();
        in_instr = 32'h9ABC_DEF0;
        step();
        in_valid = 1'b0;
        chk("pre_rst_full", bus0.in_ready, 1'b0);
        async_reset(1'b1);

        // Backpressure: A and B fill the buffer, C waits, then all drain in order.
        popped.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hA000_000A;
        step();
        in_instr = 32'hB000_000B;
        step();
        chk("bp_in_ready_low", bus0.in_ready, 1'b0);
        in_instr = 32'hC000_000C;
        step();
        step();
        chk("bp_head_still_a", {bus0.opcode, bus0.jaddr}, 32'hA000_000A);
        out_ready = 1'b1;
        c_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(got);
            if (got) begin
                in_valid = 1'b0;
                c_in = 1'b1;
            end
        end
        out_ready = 1'b0;
        chk("bp_c_accepted", c_in, 1'b1);
        chk("bp_pop_count", popped.size(), 3);
        if (popped.size() == 3) begin
            chk("bp_order_a", popped[0], 32'hA000_000A);
            chk("bp_order_b", popped[1], 32'hB000_000B);
            chk("bp_order_c", popped[2], 32'hC000_000C);
        end

        // Streaming: 100 cycles of continuous transfer from empty.
        async_reset(1'b0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_instr = $urandom;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("stream_dec_count", bus0.dec_count, 16'd99);

        // Flush while FULL with a push pending: the pushed word is dropped.
        in_valid = 1'b1;
        in_instr = 32'h1111_1111;
        step();
        chk("fl_prefull", bus0.in_ready, 1'b0);
        flush    = 1'b1;
        in_instr = 32'h2222_2222;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", bus0.out_valid, 1'b0);
        chk("fl_in_ready", bus0.in_ready, 1'b1);
        step();
        chk("fl_word_dropped", bus0.out_valid, 1'b0);

        // Flush coinciding with a pop still counts the handshake.
        in_valid = 1'b1;
        in_instr = 32'h3333_3333;
        step();
        in_instr = 32'h4444_4444;
        step();
        in_valid  = 1'b0;
        base      = bus0.dec_count;
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        flush     = 1'b0;
        out_ready = 1'b0;
        chk("fl_pop_counted", bus0.dec_count, 16'(base + 1));
        chk("fl_pop_empty", bus0.out_valid, 1'b0);

        // Counter wrap on the 4-bit instance: 17 pops, then an all-zero word.
        async_reset(1'b0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_instr = $urandom;
            step();
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        chk("wrap_dec_count", bus1.dec_count, 4'd1);
        in_valid = 1'b1;
        in_instr = 32'h0000_0000;
        step();
        in_valid = 1'b0;
        chk("wrap_rtype", bus1.is_rtype, 1'b1);
        chk("wrap_zero_fields", {bus1.opcode, bus1.jaddr, bus1.imm_ext}, 64'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 19) == 0);
            in_instr  = $urandom;
            step();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
